weight_load_ctrl: RTL and testbench
===================================

// Module: weight_load_ctrl
// PURPOSE
//  Sequences double-buffered weight loading into the systolic PE array. It accepts one row of weights
//  per beat and drives accept_w/index/weight into the north edge of every column, so each PE latches
//  the weight whose index matches its ROW_ID into its inactive register. Once the whole tile has
//  propagated down the array, it issues a one-cycle switch pulse on the west edge of every row when
//  the input scheduler requests a swap at a tile boundary.
// PARAMETERS
//  SYSTOLIC_ARRAY_WIDTH  16  rows = columns of the PE array (W)
//  DATA_WIDTH_IN         8   signed weight width
//  INDEX_WIDTH           $clog2(SYSTOLIC_ARRAY_WIDTH)  row-index tag width (localparam)
// PORTS
//  clk               in   1        clock
//  rst_n             in   1        asynchronous active-low reset
//  w_valid           in   1        weight-row beat valid
//  w_ready           out  1        beat accepted when w_valid & w_ready
//  w_data            in   W*DIN    row weights; column c in bits [c*DIN +: DIN]
//  w_col_mask        in   W        per-column enable for this beat (0: column not loaded)
//  sa_accept_w_out   out  W        accept_w per column (north edge)
//  sa_index_out      out  IW       row tag shared by all columns
//  sa_weight_out     out  W*DIN    weight per column (north edge)
//  sa_switch_out     out  W        switch pulse per row (west edge)
//  sw_req            in   1        level; asserted by the scheduler, held until sw_ack
//  sw_ack            out  1        one-cycle pulse, coincident with sa_switch_out
//  shadow_ready      out  1        inactive buffers hold a complete tile
//  active_valid      out  1        a tile has been switched into the active buffers since reset
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state LOAD, row_cnt=0, drain_cnt=0. A reset during a load
//   abandons the partial tile; PE contents are don't-care until the next full load and switch.
//  FSM: LOAD -> DRAIN -> READY -> SWITCH -> LOAD.
//   LOAD:   w_ready=1. Each accepted beat registers outputs on the next cycle:
//           sa_accept_w_out=w_col_mask, sa_index_out=row_cnt, sa_weight_out=w_data.
//           row_cnt increments from 0 to W-1. The beat accepted with row_cnt==W-1 moves to DRAIN
//           and wraps row_cnt to 0.
//           If no beat is accepted, sa_accept_w_out=0 next cycle (bubble). The PE chain tolerates
//           bubbles. sa_weight_out/sa_index_out hold their last values.
//   DRAIN:  w_ready=0. drain_cnt counts W cycles, which covers propagation to row W-1.
//           shadow_ready rises W+1 cycles after the edge that accepted the last beat.
//   READY:  shadow_ready=1, w_ready=0. If sw_req=1, go to SWITCH.
//   SWITCH: one cycle, registered: sa_switch_out=all-ones, sw_ack=1. Then shadow_ready=0,
//           active_valid=1, next state LOAD. w_ready returns to 1 the cycle after the pulse.
//  sw_req during LOAD/DRAIN is held off (no ack). It is served on the first READY cycle, with the
//   pulse on the following cycle.
//  sw_req dropped before sw_ack: no switch is issued, and the controller stays in READY.
//  w_valid while w_ready=0: ignored, no data lost. The upstream must hold the beat.
//  An all-zero w_col_mask beat still consumes a row slot (row_cnt advances).
//  No arithmetic beyond the counters. row_cnt and drain_cnt wrap exactly at W, with no overflow.
// CONFIGURATION
//  WLC_PERF_CNT_EN defined:
//   - Adds port perf_stall_cycles (out, 32). It counts cycles with sw_req=1 and state!=READY/SWITCH.
//   - The counter saturates at 2^32-1 and resets to 0.
//  Not defined: the port and counter are absent. All other behaviour is identical.
// TESTING (W=4, DIN=8)
//  1 Reset mid-LOAD after 2 beats -> all outputs 0 immediately; re-load 4 beats -> indices 0,1,2,3.
//  2 Beats {1,2,3,4},{5..8},{9..12},{13..16} back-to-back, mask 4'hF -> sa_index_out 0,1,2,3 on
//    consecutive cycles; shadow_ready high after edge N+5 (N = edge of last accept).
//  3 sw_req asserted during LOAD -> no sw_ack until READY; then sa_switch_out=4'hF and sw_ack for
//    exactly one cycle; active_valid=1; w_ready=1 next cycle.
//  4 Gapped beats (w_valid toggling) -> sa_accept_w_out=0 on bubble cycles; index sequence intact;
//    mask 4'b0101 -> sa_accept_w_out=4'b0101.
//  5 w_valid held high during DRAIN/READY -> w_ready=0, no output change; the held beat is taken as
//    row 0 of the next tile after the switch.
//  6 WLC_PERF_CNT_EN defined: sw_req raised 3 cycles before READY -> perf_stall_cycles=3.

Source files
------------

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl
// Sequences double-buffered weight loading into a W x W systolic PE array.
// One row of weights is accepted per beat and broadcast on the north edge
// together with its row tag. After the tile has drained down the array the
// controller waits for a swap request and fires a one-cycle switch pulse on
// the west edge of every row.
// Optional feature: define WLC_PERF_CNT_EN to add the perf_stall_cycles port,
// which counts cycles spent with a swap request pending outside READY/SWITCH.
module weight_load_ctrl #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            w_valid,
  output logic                                            w_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]   w_data,
  input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 w_col_mask,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 sa_accept_w_out,
  output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0]         sa_index_out,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]   sa_weight_out,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 sa_switch_out,
  input  logic                                            sw_req,
  output logic                                            sw_ack,
  output logic                                            shadow_ready,
`ifdef WLC_PERF_CNT_EN
  output logic [31:0]                                     perf_stall_cycles,
`endif
  output logic                                            active_valid
);

  localparam int W           = SYSTOLIC_ARRAY_WIDTH;
  localparam int DIN         = DATA_WIDTH_IN;
  localparam int INDEX_WIDTH = $clog2(SYSTOLIC_ARRAY_WIDTH);
  localparam int IW          = INDEX_WIDTH;

  // Last row tag; both counters wrap here so they never overflow.
  localparam logic [IW-1:0] LAST_ROW = IW'(W - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_READY  = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [IW-1:0] row_cnt_r;
  logic [IW-1:0] row_cnt_s;
  logic [IW-1:0] drain_cnt_r;
  logic [IW-1:0] drain_cnt_s;
  logic          accept_s;

  // A beat is taken only while the registered ready is high.
  assign accept_s = w_valid & w_ready;

  // Next-state and counter logic for the load/drain/ready/switch sequence.
  always_comb begin
    state_s     = state_r;
    row_cnt_s   = row_cnt_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      ST_LOAD: begin
        if (accept_s) begin
          if (row_cnt_r == LAST_ROW) begin
            row_cnt_s = {IW{1'b0}};
            state_s   = ST_DRAIN;
          end else begin
            row_cnt_s = row_cnt_r + IW'(1);
          end
        end else begin
          row_cnt_s = row_cnt_r;
        end
      end
      ST_DRAIN: begin
        // W cycles let the last row's weight ripple down to row W-1.
        if (drain_cnt_r == LAST_ROW) begin
          drain_cnt_s = {IW{1'b0}};
          state_s     = ST_READY;
        end else begin
          drain_cnt_s = drain_cnt_r + IW'(1);
        end
      end
      ST_READY: begin
        if (sw_req) begin
          state_s = ST_SWITCH;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_SWITCH: begin
        state_s = ST_LOAD;
      end
      default: begin
        state_s     = ST_LOAD;
        row_cnt_s   = {IW{1'b0}};
        drain_cnt_s = {IW{1'b0}};
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_LOAD;
      row_cnt_r   <= {IW{1'b0}};
      drain_cnt_r <= {IW{1'b0}};
    end else begin
      state_r     <= state_s;
      row_cnt_r   <= row_cnt_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // Registered north-edge load outputs; index/weight hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ready         <= 1'b0;
      sa_accept_w_out <= {W{1'b0}};
      sa_index_out    <= {IW{1'b0}};
      sa_weight_out   <= {(W*DIN){1'b0}};
    end else begin
      w_ready         <= (state_s == ST_LOAD);
      sa_accept_w_out <= accept_s ? w_col_mask : {W{1'b0}};
      if (accept_s) begin
        sa_index_out  <= row_cnt_r;
        sa_weight_out <= w_data;
      end
    end
  end

  // Registered swap handshake and buffer status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_switch_out <= {W{1'b0}};
      sw_ack        <= 1'b0;
      shadow_ready  <= 1'b0;
      active_valid  <= 1'b0;
    end else begin
      sa_switch_out <= (state_s == ST_SWITCH) ? {W{1'b1}} : {W{1'b0}};
      sw_ack        <= (state_s == ST_SWITCH);
      shadow_ready  <= (state_r == ST_READY);
      active_valid  <= active_valid | (state_r == ST_SWITCH);
    end
  end

`ifdef WLC_PERF_CNT_EN
  logic stall_s;

  // A pending swap request is stalled whenever the tile is not yet swappable.
  assign stall_s = sw_req & (state_r != ST_READY) & (state_r != ST_SWITCH);

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= 32'd0;
    end else if (stall_s && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl (W=4, DIN=8).
// A cycle-level model tracks tile progress by edge numbers and is compared
// against every DUT output after every clock edge; directed literal checks
// pin the model on the key scenarios.
module tb_weight_load_ctrl;

  localparam int W   = 4;
  localparam int DIN = 8;
  localparam int IW  = 2;

  logic               clk;
  logic               rst_n;
  logic               w_valid;
  logic               w_ready;
  logic [W*DIN-1:0]   w_data;
  logic [W-1:0]       w_col_mask;
  logic [W-1:0]       sa_accept_w_out;
  logic [IW-1:0]      sa_index_out;
  logic [W*DIN-1:0]   sa_weight_out;
  logic [W-1:0]       sa_switch_out;
  logic               sw_req;
  logic               sw_ack;
  logic               shadow_ready;
  logic               active_valid;
`ifdef WLC_PERF_CNT_EN
  logic [31:0]        perf_stall_cycles;
  logic [31:0]        e_perf;
`endif

  weight_load_ctrl #(
    .SYSTOLIC_ARRAY_WIDTH(W),
    .DATA_WIDTH_IN(DIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_data(w_data),
    .w_col_mask(w_col_mask),
    .sa_accept_w_out(sa_accept_w_out),
    .sa_index_out(sa_index_out),
    .sa_weight_out(sa_weight_out),
    .sa_switch_out(sa_switch_out),
    .sw_req(sw_req),
    .sw_ack(sw_ack),
    .shadow_ready(shadow_ready),
`ifdef WLC_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .active_valid(active_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  int               ed      = 0;   // edge number
  int               m_beats = 0;   // rows received in the current tile
  int               m_full  = -1;  // edge that took the last row, -1 while loading
  int               m_pulse = -1;  // edge of the switch pulse, -1 if none
  bit               last_acc;
  logic             e_w_ready;
  logic [W-1:0]     e_accept;
  logic [IW-1:0]    e_index;
  logic [W*DIN-1:0] e_weight;
  logic [W-1:0]     e_switch;
  logic             e_ack;
  logic             e_shadow;
  logic             e_active;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ed);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_clear();
    m_beats   = 0;
    m_full    = -1;
    m_pulse   = -1;
    e_w_ready = 1'b0;
    e_accept  = '0;
    e_index   = '0;
    e_weight  = '0;
    e_switch  = '0;
    e_ack     = 1'b0;
    e_shadow  = 1'b0;
    e_active  = 1'b0;
`ifdef WLC_PERF_CNT_EN
    e_perf    = 32'd0;
`endif
  endtask

  task automatic compare_all();
    check("w_ready", w_ready, e_w_ready);
    check("accept_w", sa_accept_w_out, e_accept);
    check("index", sa_index_out, e_index);
    check("weight", sa_weight_out, e_weight);
    check("switch", sa_switch_out, e_switch);
    check("sw_ack", sw_ack, e_ack);
    check("shadow_ready", shadow_ready, e_shadow);
    check("active_valid", active_valid, e_active);
`ifdef WLC_PERF_CNT_EN
    check("perf_stall", perf_stall_cycles, e_perf);
`endif
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit in_ready;
    bit in_switch;
    @(posedge clk);
    ed++;
    in_ready  = (m_full >= 0) && (ed > m_full + W) && (m_pulse < 0);
    in_switch = (m_pulse >= 0) && (ed == m_pulse + 1);
    last_acc  = w_valid && e_w_ready;
`ifdef WLC_PERF_CNT_EN
    if (sw_req && !in_ready && !in_switch && (e_perf != 32'hFFFF_FFFF)) e_perf = e_perf + 32'd1;
`endif
    e_switch = '0;
    e_ack    = 1'b0;
    if (in_switch) begin
      m_full   = -1;
      m_pulse  = -1;
      e_active = 1'b1;
    end else if (in_ready && sw_req) begin
      m_pulse  = ed;
      e_switch = {W{1'b1}};
      e_ack    = 1'b1;
    end
    e_shadow = in_ready;
    if (last_acc) begin
      e_accept = w_col_mask;
      e_index  = m_beats[IW-1:0];
      e_weight = w_data;
      m_beats++;
      if (m_beats == W) begin
        m_beats = 0;
        m_full  = ed;
      end
    end else begin
      e_accept = '0;
    end
    e_w_ready = (m_full < 0);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_accept", sa_accept_w_out, 4'h0);
    check("rst_index", sa_index_out, 2'd0);
    check("rst_weight", sa_weight_out, 32'h0);
    check("rst_switch", sa_switch_out, 4'h0);
    check("rst_ack", sw_ack, 1'b0);
    check("rst_shadow", shadow_ready, 1'b0);
    check("rst_active", active_valid, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one beat and hold it until the model says it was taken.
  task automatic beat(input logic [W*DIN-1:0] d, input logic [W-1:0] m);
    int n;
    n          = 0;
    w_valid    = 1'b1;
    w_data     = d;
    w_col_mask = m;
    last_acc   = 1'b0;
    while (!last_acc && n < 40) begin
      step();
      n++;
    end
    if (!last_acc) begin
      n_total++;
      $display("FAIL beat_timeout: beat %0h not accepted within 40 cycles", d);
    end
  endtask

  task automatic wait_ack(output int ack_edge);
    int n;
    n        = 0;
    ack_edge = -1;
    while (sw_ack !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (sw_ack === 1'b1) begin
      ack_edge = ed;
    end else begin
      n_total++;
      $display("FAIL ack_timeout: no sw_ack within 20 cycles");
    end
  endtask

  initial begin
    int n_last;
    int ack_edge;
    rst_n      = 1'b1;
    w_valid    = 1'b0;
    w_data     = '0;
    w_col_mask = '0;
    sw_req     = 1'b0;
    model_clear();
    do_reset();

    // 1: two beats, then reset mid-load
    beat(32'h11111111, 4'hF);
    beat(32'h22222222, 4'hF);
    w_valid = 1'b0;
    do_reset();

    // 2: back-to-back tile, indices 0..3, shadow_ready after edge N+5
    for (int i = 0; i < W; i++) begin
      beat({8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)}, 4'hF);
      check("t2_index", sa_index_out, i);
      if (i == 0) check("t2_weight0", sa_weight_out, 32'h04030201);
    end
    n_last  = ed;
    w_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t2_shadow_rise", shadow_ready, (k >= 5));
    end
    sw_req = 1'b1;
    step();
    check("t2_switch_pulse", sa_switch_out, 4'hF);
    check("t2_ack", sw_ack, 1'b1);
    sw_req = 1'b0;
    step();
    check("t2_ack_drop", sw_ack, 1'b0);
    check("t2_active", active_valid, 1'b1);
    check("t2_w_ready_back", w_ready, 1'b1);

    // 3+4: sw_req held during a gapped load with masks 0101 and 0000
    sw_req = 1'b1;
    beat(32'hA1A2A3A4, 4'b0101);
    check("t4_mask", sa_accept_w_out, 4'b0101);
    w_valid = 1'b0;
    step();
    check("t4_bubble", sa_accept_w_out, 4'b0000);
    beat(32'hB1B2B3B4, 4'b0000);
    check("t4_zero_mask_idx", sa_index_out, 2'd1);
    w_valid = 1'b0;
    step();
    beat(32'hC1C2C3C4, 4'b0101);
    check("t4_idx2", sa_index_out, 2'd2);
    w_valid = 1'b0;
    step();
    check("t4_hold_weight", sa_weight_out, 32'hC1C2C3C4);
    beat(32'hD1D2D3D4, 4'b0101);
    check("t4_idx3", sa_index_out, 2'd3);
    n_last  = ed;
    w_valid = 1'b0;
    wait_ack(ack_edge);
    check("t3_ack_edge", ack_edge - n_last, 5);
    check("t3_switch", sa_switch_out, 4'hF);
    sw_req = 1'b0;
    step();
    check("t3_w_ready", w_ready, 1'b1);

    // 5: beat held during DRAIN/READY becomes row 0 of the next tile
    for (int i = 0; i < W; i++) beat(32'h01010101 * (i + 1), 4'hF);
    w_valid    = 1'b1;
    w_data     = 32'hAABBCCDD;
    w_col_mask = 4'hF;
    for (int k = 0; k < 7; k++) step();
    check("t5_w_ready_low", w_ready, 1'b0);
    check("t5_no_accept", sa_accept_w_out, 4'h0);
    check("t5_hold_index", sa_index_out, 2'd3);
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    beat(32'hAABBCCDD, 4'hF);
    check("t5_row0_index", sa_index_out, 2'd0);
    check("t5_row0_weight", sa_weight_out, 32'hAABBCCDD);
    w_valid = 1'b0;
    step();

`ifdef WLC_PERF_CNT_EN
    // 6: sw_req raised three cycles before READY
    do_reset();
    for (int i = 0; i < W; i++) beat(32'h5A5A5A5A, 4'hF);
    w_valid = 1'b0;
    step();
    sw_req = 1'b1;
    wait_ack(ack_edge);
    check("t6_perf", perf_stall_cycles, 32'd3);
    sw_req = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
